fetch_request_arbiter: RTL
==========================

Name: fetch_request_arbiter

Overview:
Shares the single tile-fetch engine (BRAM read sequencer) between three requesters: weight loader, K-matrix loader and V-matrix loader.
- Picks one pending request round-robin and drives the engine's start_fetch and buffer_select.
- Holds buffer_select stable until the engine's fetch_done, then returns a done pulse to the winning requester.
- Sequences pointer-clear requests so they never land in the middle of a fetch.

Parameters:
- NUM_REQ, 3, number of requesters; fixed at 3 (one per buffer_select code).
- SEL_WIDTH, 2, width of buffer_select.
- TIMEOUT_CYCLES, 64, WAIT-state watchdog limit; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  3  level requests: [0] weights, [1] K-matrix, [2] V-matrix. Each requester holds its bit until its done bit pulses.
- clr_ptrs  in  1  one-cycle pulse requesting a clear of all engine address pointers.
- fetch_done  in  1  engine completion pulse.
- grant  out  3  one-hot; owner of the engine, held from ISSUE through WAIT.
- done  out  3  one-cycle completion pulse to the granted requester.
- start_fetch  out  1  one-cycle pulse to the engine.
- buffer_select  out  2  00 = weights, 01 = K, 10 = V; 11 is never driven.
- reset_addr_counters  out  1  one-cycle pulse to the engine.
- busy  out  1  high in ISSUE or WAIT.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = 2 (so req[0] has first priority); clear_pending = 0; watchdog counter = 0.
- Reset mid-operation: everything returns to reset values immediately. The engine shares rst_n, so no in-flight fetch survives.
- FSM states: IDLE, CLEAR, ISSUE, WAIT.
- IDLE:
  - If clear_pending or clr_ptrs is set: go to CLEAR. Clear has priority over any request.
  - Else, if any unmasked req is set: pick the winner by round-robin, searching from last_grant+1 and wrapping, with last_grant searched last. Register grant, buffer_select and last_grant, then go to ISSUE.
- CLEAR: reset_addr_counters = 1 for exactly one cycle; clear_pending <= 0; go to IDLE.
- ISSUE: start_fetch = 1 for exactly one cycle; go to WAIT.
- WAIT:
  - On fetch_done: register done[last_grant] = 1, clear grant, go to IDLE.
  - buffer_select is not updated until the next IDLE-to-ISSUE transition. It is therefore valid during the engine's fetch_done cycle, when the engine advances the per-buffer pointer.
- clr_ptrs arriving in ISSUE or WAIT: set clear_pending. The clear is emitted after the current fetch and before the next grant. Multiple pulses collapse into one clear.
- Masking: in the IDLE cycle where done[i] = 1, req[i] is ignored. This prevents a re-grant before the requester drops its req.
- Latency, for req sampled in IDLE at cycle N:
  - grant and buffer_select valid, and start_fetch high, at N+1.
  - done at F+1, where F is the fetch_done cycle (F = N+4 with a 2-beat engine).
- Combined latency: at most one transaction is outstanding. start_fetch is never asserted while busy was high in the previous cycle, except in ISSUE.
- Invariants (assertable):
  - grant has at most one bit set.
  - done is a subset of the previous cycle's grant.
  - start_fetch and reset_addr_counters are never high together.
- A fetch_done seen outside WAIT is ignored.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- With it defined:
  - A counter runs in WAIT. If it reaches TIMEOUT_CYCLES without fetch_done, set timeout_err (sticky until rst_n), pulse done[last_grant], clear grant, and go to IDLE.
  - The counter clears on entering WAIT.
- Without it: WAIT waits indefinitely, no counter is built, and timeout_err is tied 0.

Decomposition:
- Package fetch_arb_pkg holds:
  - buffer select codes: SEL_WEIGHT = 2'b00, SEL_K = 2'b01, SEL_V = 2'b10;
  - FSM state encodings;
  - NUM_REQ.
- Sub-module rr_pick3: combinational round-robin picker. Inputs are masked req[2:0] and last_grant; outputs are one-hot winner, winner index and valid.

Test Plan:
- Arbitration latency: req = 3'b010 at cycle 0 (IDLE); engine model with 2 beats -> start_fetch and buffer_select = 01 at cycle 1, fetch_done at cycle 4, done = 3'b010 at cycle 5, busy low at cycle 5.
- Round-robin fairness: req = 3'b111 held continuously -> grant sequence 001, 010, 100, 001; buffer_select 00, 01, 10, 00.
- Clear sequencing: clr_ptrs pulsed twice during WAIT -> exactly one reset_addr_counters pulse, in the cycle after IDLE is re-entered; the next start_fetch comes at least 2 cycles later.
- buffer_select hold: switch req from K to V while the K fetch is in flight -> buffer_select = 01 through the fetch_done cycle; the model increments only the K pointer.
- Reset mid-operation: rst_n low during WAIT -> all outputs 0 immediately; after release with req = 3'b101, weights (index 0) is granted first.
- Watchdog: FETCH_TIMEOUT_EN defined, TIMEOUT_CYCLES = 8, fetch_done never asserted -> timeout_err = 1 and the done pulse 8 cycles after entering WAIT, then the next request is served normally.

Source files
------------

// File: rtl/fetch_arb_pkg.sv
// Shared types for the fetch request arbiter: buffer select codes, FSM states
// and the round-robin helpers used by the picker and the top level.
package fetch_arb_pkg;

  localparam int NUM_REQ   = 3;
  localparam int SEL_WIDTH = 2;

  typedef logic [SEL_WIDTH-1:0] sel_t;

  localparam sel_t SEL_WEIGHT = 2'b00;
  localparam sel_t SEL_K      = 2'b01;
  localparam sel_t SEL_V      = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } arb_state_e;

  // Requester index following i, wrapping 2 -> 0.
  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return (i >= 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic sel_t idx_to_sel(input logic [1:0] idx);
    case (idx)
      2'd0:    return SEL_WEIGHT;
      2'd1:    return SEL_K;
      default: return SEL_V;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational three-way round-robin picker: searches from last+1, wrapping,
// with the previous winner considered last.
module rr_pick3
  import fetch_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [1:0]         last_i,
  output logic [NUM_REQ-1:0] winner_o,
  output logic [1:0]         idx_o,
  output logic               valid_o
);

  logic [1:0] probe;
  logic       found;

  always_comb begin
    winner_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    probe    = last_i;
    for (int k = 0; k < NUM_REQ; k++) begin
      probe = rr_next(probe);
      if (!found && req_i[probe]) begin
        found = 1'b1;
        idx_o = probe;
      end
    end
    if (found) winner_o = NUM_REQ'(1) << idx_o;
    valid_o = found;
  end

endmodule

// File: rtl/fetch_request_arbiter.sv
// Shares the tile-fetch engine between the weight, K and V loaders and sequences
// pointer clears between fetches. Define FETCH_TIMEOUT_EN to build the WAIT watchdog.
module fetch_request_arbiter
  import fetch_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               clr_ptrs_i,
  input  logic               fetch_done_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [NUM_REQ-1:0] done_o,
  output logic               start_fetch_o,
  output sel_t               buffer_select_o,
  output logic               reset_addr_counters_o,
  output logic               busy_o,
  output logic               timeout_err_o
);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  sel_t               sel_q, sel_d;
  logic [1:0]         last_q, last_d;
  logic               clear_pending_q, clear_pending_d;

  logic [NUM_REQ-1:0] req_masked;
  logic [NUM_REQ-1:0] pick_winner;
  logic [1:0]         pick_idx;
  logic               pick_valid;
  logic               timeout_hit;

  // A requester whose done is pulsing has not yet had a chance to drop req.
  assign req_masked = req_i & ~done_q;

  rr_pick3 u_pick (
    .req_i    (req_masked),
    .last_i   (last_q),
    .winner_o (pick_winner),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             timeout_err_q, timeout_err_d;

  always_comb begin
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = timeout_err_q;
    timeout_hit   = 1'b0;
    if (state_q == ST_ISSUE) begin
      wd_cnt_d = '0;
    end else if (state_q == ST_WAIT && !fetch_done_i) begin
      if (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        timeout_hit   = 1'b1;
        timeout_err_d = 1'b1;
        wd_cnt_d      = '0;
      end else begin
        wd_cnt_d = wd_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err_o = timeout_err_q;
`else
  assign timeout_hit   = 1'b0;
  assign timeout_err_o = 1'b0;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_cfg_unused
  end
`endif

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    done_d          = '0;
    sel_d           = sel_q;
    last_d          = last_q;
    clear_pending_d = clear_pending_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_pending_q || clr_ptrs_i) begin
          state_d = ST_CLEAR;
        end else if (pick_valid) begin
          grant_d = pick_winner;
          sel_d   = idx_to_sel(pick_idx);
          last_d  = pick_idx;
          state_d = ST_ISSUE;
        end
      end
      ST_CLEAR: begin
        clear_pending_d = 1'b0;
        state_d         = ST_IDLE;
      end
      ST_ISSUE: begin
        if (clr_ptrs_i) clear_pending_d = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (clr_ptrs_i) clear_pending_d = 1'b1;
        // sel_q is left alone so the engine still sees it on the fetch_done cycle.
        if (fetch_done_i || timeout_hit) begin
          done_d  = NUM_REQ'(1) << last_q;
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      grant_q         <= '0;
      done_q          <= '0;
      sel_q           <= SEL_WEIGHT;
      last_q          <= 2'd2;
      clear_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      done_q          <= done_d;
      sel_q           <= sel_d;
      last_q          <= last_d;
      clear_pending_q <= clear_pending_d;
    end
  end

  assign grant_o               = grant_q;
  assign done_o                = done_q;
  assign buffer_select_o       = sel_q;
  assign start_fetch_o         = (state_q == ST_ISSUE);
  assign reset_addr_counters_o = (state_q == ST_CLEAR);
  assign busy_o                = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

endmodule
